instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Front-end stage of the pipelined CPU: owns the program counter, addresses the instruction memory and registers a 9-bit instruction into the IF/ID latch.
- The latched instruction feeds the downstream decode/control stage.
- Accepts a run start, decoded halt, resolved branch redirects and pipeline stalls.
- Reports run status and a count of issued instructions to the testbench/top level.

Parameters:
PC_WIDTH, 8, width of program counter and instruction-memory address
INSTR_WIDTH, 9, instruction width
NOP_INSTR, 9'b110110000, encoding driven on instruction_out for bubbles (reserved opcode 11011; performs no register or memory write)
CNT_WIDTH, 16, width of issued-instruction counter

Ports:
clk  in  1  single system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
start_req  in  1  single-cycle request to begin execution at PC 0
halt_in  in  1  decode stage reports a halt instruction in ID
branch_taken  in  1  downstream stage resolved a taken branch/jump this cycle
branch_target  in  PC_WIDTH  redirect address, valid when branch_taken=1
stall  in  1  hold PC and IF/ID latch (hazard)
imem_addr  out  PC_WIDTH  instruction memory address (= current PC, combinational)
imem_data  in  INSTR_WIDTH  instruction memory read data, combinational from imem_addr
instruction_out  out  INSTR_WIDTH  IF/ID latched instruction
pc_out  out  PC_WIDTH  PC of instruction_out
valid_out  out  1  instruction_out is a real instruction, not a bubble
running  out  1  state = RUN
done  out  1  state = HALTED
fetch_count  out  CNT_WIDTH  instructions issued since last start

Behaviour:
- Reset (rst_n=0 at a clock edge) overrides everything, including in mid-run:
  - state=IDLE, pc=0, instruction_out=NOP_INSTR, pc_out=0, valid_out=0, fetch_count=0, running=0, done=0.
- FSM states: IDLE, RUN, HALTED.
  - IDLE -> RUN on start_req.
  - RUN -> HALTED on halt_in.
  - HALTED -> RUN on start_req.
  - No other transitions.
  - start_req is ignored while in RUN.
- On start_req (from IDLE or HALTED): pc<=0, fetch_count<=0, IF/ID latch <= bubble (NOP_INSTR, valid_out=0). The first instruction appears on instruction_out one cycle later, i.e. fetch latency is 1 cycle.
- IDLE and HALTED: pc, IF/ID latch and fetch_count hold; valid_out=0.
- RUN priority per cycle, highest first:
  1. halt_in: state<=HALTED; latch<=bubble; pc holds (points at the instruction after the halt); fetch_count holds.
  2. branch_taken: pc<=branch_target; latch<=bubble (flushes the wrong-path fetch); fetch_count holds. Applies even when stall=1.
  3. stall: pc, instruction_out, pc_out and valid_out all hold.
  4. Normal: instruction_out<=imem_data; pc_out<=pc; valid_out<=1; pc<=pc+1; fetch_count<=fetch_count+1.
- PC arithmetic is modulo 2^PC_WIDTH: 8'hFF+1 wraps to 8'h00 with no flag.
- fetch_count saturates at all-ones; it does not wrap.
- imem_addr = pc at all times, including IDLE and HALTED.
- running and done are decoded from registered state, so they change 1 cycle after the causing event.
- Bubble definition: instruction_out=NOP_INSTR, pc_out unchanged, valid_out=0.

Test Plan:
- Reset then start: rst_n low 2 cycles, start_req pulse, imem returns 9'h010+addr -> cycle after start: valid_out=0; then instruction_out=9'h010, 9'h011, 9'h012 with pc_out 0,1,2 and fetch_count 1,2,3.
- Branch flush: at pc=5 assert branch_taken with branch_target=8'h20 (stall=1 same cycle) -> next cycle valid_out=0 and imem_addr=8'h20; following cycle pc_out=8'h20, valid_out=1.
- Stall hold: 3-cycle stall at pc=3 -> instruction_out, pc_out and imem_addr constant for 3 cycles; fetch_count unchanged; resumes with pc_out=3.
- Halt with simultaneous branch: halt_in=1 and branch_taken=1 at pc=7 -> done=1 next cycle, valid_out=0, imem_addr stays 7; a later start_req restarts at pc_out=0 with fetch_count=0.
- Wrap: branch to 8'hFE, run 3 cycles -> pc_out sequence FE, FF, 00.
- Mid-run reset: rst_n=0 for 1 cycle while in RUN at pc=0x40 -> all outputs at reset values next cycle and running=0; subsequent start_req is required before any instruction issues.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: front-end pipeline stage. Owns the program counter,
// addresses instruction memory combinationally and registers the fetched
// instruction into the IF/ID latch. Handles run start, halt, branch redirect
// and stall, and counts issued instructions.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   start_req         begin execution at PC 0 (from IDLE or HALTED)
//   halt_in           halt instruction decoded in ID
//   branch_taken      taken branch/jump resolved this cycle
//   branch_target     redirect address
//   stall             hold PC and IF/ID latch
//   imem_addr         instruction memory address (= PC)
//   imem_data         instruction memory read data
//   instruction_out   IF/ID latched instruction
//   pc_out            PC of instruction_out
//   valid_out         instruction_out is real (not a bubble)
//   running, done     state = RUN / state = HALTED
//   fetch_count       instructions issued since last start (saturating)
module instruction_fetch #(
    parameter int unsigned          PC_WIDTH    = 8,
    parameter int unsigned          INSTR_WIDTH = 9,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 9'b110110000,
    parameter int unsigned          CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_req,
    input  logic                   halt_in,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   stall,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instruction_out,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic                   valid_out,
    output logic                   running,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   fetch_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    pc_out_q, pc_out_d;
    logic                   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            instr_q  <= NOP_INSTR;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = 1'b0;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE, HALTED: begin
                if (start_req) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                    instr_d = NOP_INSTR;
                end
            end
            RUN: begin
                if (halt_in) begin
                    // PC holds so it points at the instruction after the halt.
                    state_d = HALTED;
                    instr_d = NOP_INSTR;
                end else if (branch_taken) begin
                    // Redirect wins over stall; the wrong-path fetch is flushed.
                    pc_d    = branch_target;
                    instr_d = NOP_INSTR;
                end else if (stall) begin
                    valid_d = valid_q;
                end else begin
                    instr_d  = imem_data;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_addr       = pc_q;
    assign instruction_out = instr_q;
    assign pc_out          = pc_out_q;
    assign valid_out       = valid_q;
    assign running         = (state_q == RUN);
    assign done            = (state_q == HALTED);
    assign fetch_count     = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam logic [8:0] NOP = 9'b110110000;

    logic       clk;
    logic       rst_n;
    logic       start_req;
    logic       halt_in;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       stall;
    logic [7:0] imem_addr;
    logic [8:0] imem_data;
    logic [8:0] instruction_out;
    logic [7:0] pc_out;
    logic       valid_out;
    logic       running;
    logic       done;
    logic [15:0] fetch_count;

    int checks;
    int failures;

    instruction_fetch #(
        .PC_WIDTH   (8),
        .INSTR_WIDTH(9),
        .NOP_INSTR  (9'b110110000),
        .CNT_WIDTH  (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_req      (start_req),
        .halt_in        (halt_in),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .stall          (stall),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instruction_out(instruction_out),
        .pc_out         (pc_out),
        .valid_out      (valid_out),
        .running        (running),
        .done           (done),
        .fetch_count    (fetch_count)
    );

    // Instruction memory model: word at address a is 9'h010 + a.
    assign imem_data = 9'h010 + {1'b0, imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fetch(input string tag, input logic [8:0] instr,
                               input logic [7:0] pc, input logic [15:0] cnt);
        check({tag, "_instr"}, 32'(instruction_out), 32'(instr));
        check({tag, "_pc"},    32'(pc_out),          32'(pc));
        check({tag, "_valid"}, 32'(valid_out),       32'd1);
        check({tag, "_cnt"},   32'(fetch_count),     32'(cnt));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        start_req     = 1'b0;
        halt_in       = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        stall         = 1'b0;

        // Reset
        step();
        step();
        check("rst_instr",   32'(instruction_out), 32'(NOP));
        check("rst_pc_out",  32'(pc_out),          32'h0);
        check("rst_valid",   32'(valid_out),       32'h0);
        check("rst_running", 32'(running),         32'h0);
        check("rst_done",    32'(done),            32'h0);
        check("rst_cnt",     32'(fetch_count),     32'h0);
        check("rst_addr",    32'(imem_addr),       32'h0);

        rst_n = 1'b1;
        step();
        check("idle_running", 32'(running),   32'h0);
        check("idle_valid",   32'(valid_out), 32'h0);

        // Start and first fetches
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        check("start_running", 32'(running),   32'h1);
        check("start_valid",   32'(valid_out), 32'h0);
        check("start_addr",    32'(imem_addr), 32'h0);
        step();
        check_fetch("f0", 9'h010, 8'h00, 16'd1);
        step();
        check_fetch("f1", 9'h011, 8'h01, 16'd2);
        step();
        check_fetch("f2", 9'h012, 8'h02, 16'd3);

        // Stall for 3 cycles at pc=3
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_fetch("stall", 9'h012, 8'h02, 16'd3);
            check("stall_addr", 32'(imem_addr), 32'h3);
        end
        stall = 1'b0;
        step();
        check_fetch("resume3", 9'h013, 8'h03, 16'd4);
        step();
        check_fetch("f4", 9'h014, 8'h04, 16'd5);

        // Branch at pc=5 with simultaneous stall
        branch_taken  = 1'b1;
        branch_target = 8'h20;
        stall         = 1'b1;
        step();
        branch_taken = 1'b0;
        stall        = 1'b0;
        check("br_valid",  32'(valid_out),       32'h0);
        check("br_instr",  32'(instruction_out), 32'(NOP));
        check("br_pc_out", 32'(pc_out),          32'h04);
        check("br_addr",   32'(imem_addr),       32'h20);
        check("br_cnt",    32'(fetch_count),     32'd5);
        step();
        check_fetch("br_tgt", 9'h030, 8'h20, 16'd6);

        // Redirect to pc=7, then halt with simultaneous branch
        branch_taken  = 1'b1;
        branch_target = 8'h07;
        step();
        check("to7_addr", 32'(imem_addr), 32'h07);
        branch_target = 8'h55;
        halt_in       = 1'b1;
        step();
        halt_in      = 1'b0;
        branch_taken = 1'b0;
        check("halt_done",    32'(done),        32'h1);
        check("halt_running", 32'(running),     32'h0);
        check("halt_valid",   32'(valid_out),   32'h0);
        check("halt_addr",    32'(imem_addr),   32'h07);
        check("halt_cnt",     32'(fetch_count), 32'd6);
        step();
        check("halted_addr",  32'(imem_addr),   32'h07);
        check("halted_valid", 32'(valid_out),   32'h0);
        check("halted_cnt",   32'(fetch_count), 32'd6);

        // Restart from HALTED
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        check("restart_running", 32'(running),     32'h1);
        check("restart_done",    32'(done),        32'h0);
        check("restart_cnt",     32'(fetch_count), 32'h0);
        check("restart_valid",   32'(valid_out),   32'h0);
        check("restart_addr",    32'(imem_addr),   32'h0);
        step();
        check_fetch("restart_f0", 9'h010, 8'h00, 16'd1);

        // PC wrap
        branch_taken  = 1'b1;
        branch_target = 8'hFE;
        step();
        branch_taken = 1'b0;
        check("wrap_addr", 32'(imem_addr), 32'hFE);
        step();
        check_fetch("wrap_fe", 9'h10E, 8'hFE, 16'd2);
        step();
        check_fetch("wrap_ff", 9'h10F, 8'hFF, 16'd3);
        step();
        check_fetch("wrap_00", 9'h010, 8'h00, 16'd4);

        // Mid-run reset at pc=0x40
        branch_taken  = 1'b1;
        branch_target = 8'h40;
        step();
        branch_taken = 1'b0;
        check("mr_addr", 32'(imem_addr), 32'h40);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mr_instr",   32'(instruction_out), 32'(NOP));
        check("mr_pc_out",  32'(pc_out),          32'h0);
        check("mr_valid",   32'(valid_out),       32'h0);
        check("mr_running", 32'(running),         32'h0);
        check("mr_done",    32'(done),            32'h0);
        check("mr_cnt",     32'(fetch_count),     32'h0);
        check("mr_addr0",   32'(imem_addr),       32'h0);
        step();
        step();
        check("mr_idle_valid",   32'(valid_out),   32'h0);
        check("mr_idle_running", 32'(running),     32'h0);
        check("mr_idle_cnt",     32'(fetch_count), 32'h0);
        check("mr_idle_addr",    32'(imem_addr),   32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
